// File: rtl/mod_acc3329.sv
// Modular accumulator for Montgomery multiplier products.
// Sums LEN consecutive terms modulo MOD without ever stalling the input,
// then presents the reduced sum on a valid/ready result register.
//
// Optional feature macro: MOD_ACC_SUB_EN adds the in_sub port; a term with
// in_sub=1 is subtracted (mod MOD) instead of added.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   term strobe (upstream done), never back-pressured
//   in_data    term value, any value 0..2^WIDTH-1
//   in_sub     (MOD_ACC_SUB_EN only) subtract this term
//   clear      flush the partial sum; wins over in_valid
//   out_valid  result register holds an unconsumed sum
//   out_ready  consumer accepts the result
//   out_data   sum modulo MOD
//   busy       partial sum in progress (term count not zero)
//   ovf        sticky: a completed sum was dropped
module mod_acc3329 #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned MOD   = 3329,
  parameter int unsigned LEN   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
`ifdef MOD_ACC_SUB_EN
  input  logic             in_sub,
`endif
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             ovf
);

  // Two guard bits cover acc (< MOD) plus a full-range term.
  localparam int unsigned SW    = WIDTH + 2;
  localparam int unsigned CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [SW-1:0]    MOD_S = SW'(MOD);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(LEN - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_acc, w_acc_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_out_valid, w_out_valid_nxt;
  logic [WIDTH-1:0]   r_out_data, w_out_data_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_ovf, w_ovf_nxt;

  logic               w_accept;
  logic               w_last;
  logic               w_complete;
  logic [SW-1:0]      w_sum;
  logic [SW-1:0]      w_s1;
  logic [SW-1:0]      w_s2;
  logic [WIDTH-1:0]   w_add;
  logic [WIDTH-1:0]   w_term;

  // Clear beats any same-cycle term.
  assign w_accept   = in_valid && !clear;
  assign w_last     = (r_cnt == LAST);
  assign w_complete = w_accept && w_last;

  // Addition path: conditional subtract of MOD, twice at most.
  assign w_sum = SW'(r_acc) + SW'(in_data);
  assign w_s1  = (w_sum >= MOD_S) ? (w_sum - MOD_S) : w_sum;
  assign w_s2  = (w_s1 >= MOD_S) ? (w_s1 - MOD_S) : w_s1;
  assign w_add = WIDTH'(w_s2);

`ifdef MOD_ACC_SUB_EN
  // Subtraction path: reduce the term into 0..MOD-1, then wrap a negative difference.
  logic [SW-1:0]    w_din;
  logic [SW-1:0]    w_r1;
  logic [SW-1:0]    w_r2;
  logic [SW-1:0]    w_acc_s;
  logic [WIDTH-1:0] w_sub;

  assign w_din   = SW'(in_data);
  assign w_r1    = (w_din >= MOD_S) ? (w_din - MOD_S) : w_din;
  assign w_r2    = (w_r1 >= MOD_S) ? (w_r1 - MOD_S) : w_r1;
  assign w_acc_s = SW'(r_acc);
  assign w_sub   = WIDTH'((w_acc_s < w_r2) ? (w_acc_s + MOD_S - w_r2) : (w_acc_s - w_r2));
  assign w_term  = in_sub ? w_sub : w_add;
`else
  assign w_term  = w_add;
`endif

  // State, accumulator and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_busy      <= w_busy_nxt;
      r_ovf       <= w_ovf_nxt;
    end
  end

  // Next-state, datapath and result handshake.
  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_ovf_nxt       = r_ovf;
    w_busy_nxt      = r_busy;

    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_last) begin
          w_state_nxt = S_ACC;
        end
      end
      S_ACC: begin
        if (clear || w_complete) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (clear) begin
      w_acc_nxt = '0;
      w_cnt_nxt = '0;
    end else if (in_valid) begin
      if (w_last) begin
        w_acc_nxt = '0;
        w_cnt_nxt = '0;
      end else begin
        w_acc_nxt = w_term;
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end

    // A completing sum may replace a result being consumed this same cycle.
    if (w_complete) begin
      if (!r_out_valid || out_ready) begin
        w_out_valid_nxt = 1'b1;
        w_out_data_nxt  = w_term;
      end else begin
        w_ovf_nxt = 1'b1;
      end
    end else if (r_out_valid && out_ready) begin
      w_out_valid_nxt = 1'b0;
    end

    w_busy_nxt = (w_cnt_nxt != '0);
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
  assign ovf       = r_ovf;

endmodule

// File: doc/mod_acc3329.md
MOD_ACC3329 -- requirements
Module: mod_acc3329

Interface
REQ-001 The block SHALL have parameter WIDTH, default 12, coefficient width in bits.
REQ-002 The block SHALL have parameter MOD, default 3329, the modulus q.
REQ-003 The block SHALL have parameter LEN, default 4, the number of terms per sum; legal range 1..256.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset; synchronous and active-low.
REQ-006 in_valid  input  1  term strobe, driven by the done output of the upstream Montgomery multiplier.
REQ-007 in_data  input  WIDTH  term value (the multiplier's r output); any value 0..2^WIDTH-1.
REQ-008 clear  input  1  synchronous flush of the partial sum.
REQ-009 out_valid  output  1  result register holds an unconsumed sum.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_data  output  WIDTH  sum modulo MOD, in range 0..MOD-1.
REQ-012 busy  output  1  a partial sum is in progress (term count not zero).
REQ-013 ovf  output  1  sticky flag: a completed sum was dropped.

Function
REQ-014 The block SHALL never stall its input, because the upstream pipeline has no backpressure; every in_valid cycle is processed.
REQ-015 Accumulator state machine:
- IDLE: acc=0, cnt=0.
- IDLE -> ACC on an accepted term when LEN>1.
- ACC -> IDLE when term LEN is accepted.
REQ-016 On each accepted term, the block SHALL set s = acc + in_data and subtract MOD while s >= MOD (at most twice), giving a result in 0..MOD-1.
REQ-017 When term LEN is accepted, the reduced sum SHALL go to the result register instead of acc, acc and cnt SHALL return to 0, and out_valid SHALL assert on the next cycle (latency 1 from the last term).
REQ-018 With LEN=1, each term SHALL produce a result directly from IDLE.
REQ-019 The result register SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-020 On a handshake (out_valid and out_ready both 1), out_valid SHALL clear on the next cycle unless a new sum completes in the same cycle; in that case the new sum SHALL load and out_valid SHALL stay 1.
REQ-021 If a sum completes while out_valid=1 and out_ready=0:
- the new sum SHALL be dropped;
- the held result SHALL be kept;
- ovf SHALL set and stay set until reset.
REQ-022 When clear=1, acc and cnt SHALL go to 0 and any in_valid in the same cycle SHALL be ignored (clear wins); the result register, out_valid and ovf SHALL be unaffected.
REQ-023 busy SHALL equal (cnt != 0), as a registered value.

Reset
REQ-024 When rst_n=0 at a rising edge, the block SHALL set acc=0, cnt=0, state=IDLE, out_valid=0, out_data=0, busy=0 and ovf=0.
REQ-025 A reset mid-group SHALL discard the partial sum, and the first term after reset release SHALL start a new group.

Configuration
REQ-026 Macro MOD_ACC_SUB_EN SHALL control a subtract-term feature.
REQ-027 When MOD_ACC_SUB_EN is defined:
- the block SHALL add input in_sub (1 bit);
- a term with in_sub=1 SHALL compute acc - in_data mod MOD: reduce in_data to 0..MOD-1 first, then add MOD if the difference is negative;
- the result SHALL stay in 0..MOD-1.
REQ-028 When MOD_ACC_SUB_EN is not defined, the in_sub port SHALL be absent and every term SHALL be added.

Verification
REQ-029 Defaults, terms 3328,3328,3328,3328 on consecutive cycles -> out_valid=1 one cycle after the 4th term, out_data=3325.
REQ-030 LEN=1, in_data=4095 -> out_data=766; in_data=3329 -> out_data=0.
REQ-031 out_ready=0, two full groups (1,2,3,4 then 10,10,10,10) -> out_data stays 10 and ovf=1; after out_ready=1, out_valid=0 on the next cycle.
REQ-032 Terms 5,6, then clear=1 with in_valid=1 (data 7), then terms 1,1,1,1 -> single result 4 and busy=0 after clear.
REQ-033 Handshake in the same cycle a new sum completes -> out_valid stays 1, out_data changes to the new sum, ovf=0.
REQ-034 rst_n=0 after 2 terms, then 4 terms of 100 -> out_data=400, ovf=0; with MOD_ACC_SUB_EN defined, terms +5,-10,+0,+0 -> 3324.
